// File: rtl/read_burst_engine_pkg.sv
// Shared encodings and state type for the AXI3 read burst engine.
// Holds the command legality check used at command acceptance.
package read_burst_engine_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_SEND
    } state_t;

    function automatic logic cmd_is_legal(input logic [1:0] burst, input logic [3:0] len,
                                          input logic [1:0] size, input int bus_bytes);
        logic ok;
        ok = 1'b1;
        if (burst == BURST_RSVD)
            ok = 1'b0;
        if (burst == BURST_WRAP && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15))
            ok = 1'b0;
        if ((1 << size) > bus_bytes)
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/read_addr_stepper.sv
// Next beat address for FIXED/INCR/WRAP bursts.
// Latency: combinational. Backpressure: none.
module read_addr_stepper
    import read_burst_engine_pkg::*;
#(
    parameter int BUSWIDTH = 32
) (
    input  logic [BUSWIDTH-1:0] addr,
    input  logic [3:0]          len,
    input  logic [1:0]          size,
    input  logic [1:0]          burst,
    output logic [BUSWIDTH-1:0] next_addr
);

    logic [BUSWIDTH-1:0] beat_bytes;
    logic [BUSWIDTH-1:0] wrap_bytes;
    logic [BUSWIDTH-1:0] lower;
    logic [BUSWIDTH-1:0] incr;

    always_comb begin
        beat_bytes = BUSWIDTH'(1) << size;
        wrap_bytes = BUSWIDTH'({1'b0, len} + 5'd1) << size;
        lower      = addr & ~(wrap_bytes - BUSWIDTH'(1));
        incr       = addr + beat_bytes;
        case (burst)
            BURST_FIXED: next_addr = addr;
            // Wrap back to the aligned window base once the step reaches its top
            BURST_WRAP:  next_addr = (incr == lower + wrap_bytes) ? lower : incr;
            default:     next_addr = incr;
        endcase
    end

endmodule

// File: rtl/read_burst_engine.sv
// AXI3 read burst engine: one device read per beat, beats returned on R channel.
// Latency: cmd handshake T -> dev_read T+1; dev_valid cycle +1 -> RVALID.
// Backpressure: R payload held while RREADY low; cmd_ready only in IDLE.
module read_burst_engine
    import read_burst_engine_pkg::*;
#(
    parameter int BUSWIDTH = 32,
    parameter int TAGBITS  = 4
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [TAGBITS-1:0]  cmd_id,
    input  logic [BUSWIDTH-1:0] cmd_addr,
    input  logic [3:0]          cmd_len,
    input  logic [1:0]          cmd_size,
    input  logic [1:0]          cmd_burst,
    output logic [BUSWIDTH-1:0] dev_addr,
    output logic                dev_read,
    input  logic [BUSWIDTH-1:0] dev_data,
    input  logic                dev_valid,
    output logic [TAGBITS-1:0]  RID,
    output logic [BUSWIDTH-1:0] RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY
);

    state_t              state;
    logic [BUSWIDTH-1:0] cur_addr;
    logic [BUSWIDTH-1:0] next_addr;
    logic [3:0]          len_r;
    logic [3:0]          beats_left;
    logic [1:0]          size_r;
    logic [1:0]          burst_r;
    logic                legal_r;
    logic                cmd_fire;
    logic                cmd_legal;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign cmd_legal = cmd_is_legal(cmd_burst, cmd_len, cmd_size, BUSWIDTH / 8);

    read_addr_stepper #(
        .BUSWIDTH (BUSWIDTH)
    ) u_stepper (
        .addr      (cur_addr),
        .len       (len_r),
        .size      (size_r),
        .burst     (burst_r),
        .next_addr (next_addr)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= ST_IDLE;
            cmd_ready  <= 1'b0;
            cur_addr   <= '0;
            len_r      <= '0;
            beats_left <= '0;
            size_r     <= '0;
            burst_r    <= '0;
            legal_r    <= 1'b0;
            dev_addr   <= '0;
            dev_read   <= 1'b0;
            RID        <= '0;
            RDATA      <= '0;
            RRESP      <= '0;
            RLAST      <= 1'b0;
            RVALID     <= 1'b0;
        end else begin
            dev_read <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_fire) begin
                        cmd_ready  <= 1'b0;
                        cur_addr   <= cmd_addr;
                        len_r      <= cmd_len;
                        beats_left <= cmd_len;
                        size_r     <= cmd_size;
                        burst_r    <= cmd_burst;
                        legal_r    <= cmd_legal;
                        RID        <= cmd_id;
                        if (cmd_legal) begin
                            dev_read <= 1'b1;
                            dev_addr <= cmd_addr;
                            state    <= ST_ISSUE;
                        end else begin
                            // Error bursts never touch the device; beats go straight out
                            RVALID <= 1'b1;
                            RDATA  <= '0;
                            RRESP  <= RESP_SLVERR;
                            RLAST  <= (cmd_len == 4'd0);
                            state  <= ST_SEND;
                        end
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (dev_valid) begin
                        RDATA  <= dev_data;
                        RRESP  <= RESP_OKAY;
                        RVALID <= 1'b1;
                        RLAST  <= (beats_left == 4'd0);
                        state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (RVALID && RREADY) begin
                        if (beats_left == 4'd0) begin
                            RVALID    <= 1'b0;
                            RLAST     <= 1'b0;
                            cmd_ready <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            cur_addr   <= next_addr;
                            beats_left <= beats_left - 4'd1;
                            if (legal_r) begin
                                RVALID   <= 1'b0;
                                dev_read <= 1'b1;
                                dev_addr <= next_addr;
                                state    <= ST_ISSUE;
                            end else begin
                                RLAST <= (beats_left == 4'd1);
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
